// File: rtl/prbs_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR stream: self-synchronises,
// declares lock, free-runs a predictor and counts mismatching words while locked.
module prbs_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  input  logic             i_clear,
  output logic             o_locked,
  output logic [1:0]       o_state,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       expected;
  logic [7:0]       match_cnt;
  logic [7:0]       bad_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= HUNT;
      expected  <= 8'h00;
      match_cnt <= 8'd0;
      bad_cnt   <= 8'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      if (i_clear) begin
        err_cnt <= '0;
      end
      if (i_valid) begin
        case (state)
          HUNT: begin
            if (i_data != 8'h00) begin
              expected  <= nxt(i_data);
              match_cnt <= 8'd0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (i_data == expected) begin
              expected  <= nxt(expected);
              match_cnt <= match_cnt + 8'd1;
              if (match_cnt + 8'd1 == 8'(LOCK_CNT)) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                bad_cnt <= 8'd0;
              end
            end else if (i_data != 8'h00) begin
              // A wrong but legal word becomes the new seed.
              expected  <= nxt(i_data);
              match_cnt <= 8'd0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            expected <= nxt(expected);
            if (i_data == expected) begin
              bad_cnt <= 8'd0;
            end else begin
              err <= 1'b1;
              if (!i_clear) begin
                err_cnt <= sat_inc(err_cnt);
              end
              if (bad_cnt + 8'd1 == 8'(LOSS_CNT)) begin
                state   <= HUNT;
                locked  <= 1'b0;
                bad_cnt <= 8'd0;
              end else begin
                bad_cnt <= bad_cnt + 8'd1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_state   = state;
  assign o_locked  = locked;
  assign o_err     = err;
  assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised and directed bench for prbs_checker: two instances (default and a
// 2-bit error counter) share one stimulus stream and are compared to a model.
module tb_prbs_checker;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_clear = 1'b0;

  logic        locked_a, err_a, locked_s, err_s;
  logic [1:0]  state_a, state_s;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .i_valid(i_valid), .i_data(i_data),
    .i_clear(i_clear), .o_locked(locked_a), .o_state(state_a),
    .o_err(err_a), .o_err_cnt(cnt_a)
  );

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) dut_s (
    .clk(clk), .arst_n(arst_n), .i_valid(i_valid), .i_data(i_data),
    .i_clear(i_clear), .o_locked(locked_s), .o_state(state_s),
    .o_err(err_s), .o_err_cnt(cnt_s)
  );

  always #5 clk = ~clk;

  // Reference model, one entry per instance.
  int         m_state [2];
  int         m_match [2];
  int         m_bad   [2];
  int         m_cnt   [2];
  int         m_err   [2];
  logic [7:0] m_exp   [2];
  int         m_max   [2] = '{65535, 3};

  logic [7:0] cur;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_state[m] = 0; m_match[m] = 0; m_bad[m] = 0;
      m_cnt[m] = 0; m_err[m] = 0; m_exp[m] = 8'h00;
    end
  endtask

  task automatic model_step(input int m, input logic v, input logic [7:0] d,
                            input logic c);
    m_err[m] = 0;
    if (v) begin
      if (m_state[m] == 0) begin
        if (d != 8'h00) begin
          m_exp[m] = nxt(d); m_match[m] = 0; m_state[m] = 1;
        end
      end else if (m_state[m] == 1) begin
        if (d == m_exp[m]) begin
          m_exp[m] = nxt(m_exp[m]);
          m_match[m]++;
          if (m_match[m] == LOCK_CNT) begin
            m_state[m] = 2; m_bad[m] = 0;
          end
        end else if (d != 8'h00) begin
          m_exp[m] = nxt(d); m_match[m] = 0;
        end else begin
          m_state[m] = 0;
        end
      end else begin
        if (d == m_exp[m]) begin
          m_bad[m] = 0;
        end else begin
          m_err[m] = 1;
          m_cnt[m] = (m_cnt[m] + 1 > m_max[m]) ? m_max[m] : m_cnt[m] + 1;
          m_bad[m]++;
          if (m_bad[m] == LOSS_CNT) begin
            m_state[m] = 0; m_bad[m] = 0;
          end
        end
        m_exp[m] = nxt(m_exp[m]);
      end
    end
    if (c) m_cnt[m] = 0;
  endtask

  task automatic compare();
    check("state",    int'(state_a),  m_state[0]);
    check("locked",   int'(locked_a), int'(m_state[0] == 2));
    check("err",      int'(err_a),    m_err[0]);
    check("cnt",      int'(cnt_a),    m_cnt[0]);
    check("state_s",  int'(state_s),  m_state[1]);
    check("locked_s", int'(locked_s), int'(m_state[1] == 2));
    check("err_s",    int'(err_s),    m_err[1]);
    check("cnt_s",    int'(cnt_s),    m_cnt[1]);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    i_valid = v; i_data = d; i_clear = c;
    @(posedge clk);
    model_step(0, v, d, c);
    model_step(1, v, d, c);
    #1;
    compare();
  endtask

  task automatic good(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, cur, 1'b0);
      cur = nxt(cur);
    end
  endtask

  task automatic bad(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, cur ^ 8'h01, 1'b0);
      cur = nxt(cur);
    end
  endtask

  task automatic async_reset();
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    check("rst_locked", int'(locked_a), 0);
    check("rst_state",  int'(state_a),  0);
    check("rst_err",    int'(err_a),    0);
    check("rst_cnt",    int'(cnt_a),    0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check("init_state", int'(state_a), 0);
    check("init_cnt",   int'(cnt_a),   0);
    @(negedge clk);
    arst_n = 1'b1;

    // Zero words in HUNT never seed.
    for (int k = 0; k < 3; k++) step(1'b1, 8'h00, 1'b0);
    check("zero_hunt", int'(state_a), 0);

    // Clean lock from 8'hDA with back-to-back words.
    cur = 8'hDA;
    good(1);
    check("seed_verify", int'(state_a), 1);
    good(LOCK_CNT - 1);
    check("not_yet_locked", int'(locked_a), 0);
    good(1);
    check("clean_lock", int'(locked_a), 1);
    good(5);

    // Asynchronous reset while locked, then the checker needs a new seed.
    async_reset();
    step(1'b0, 8'h00, 1'b0);
    check("post_rst_hunt", int'(state_a), 0);

    // Gapped valid: lock after the 9th valid word.
    cur = 8'hDA;
    for (int k = 0; k < 2 * (LOCK_CNT + 1); k++) begin
      if (k % 2 == 0) begin
        step(1'b1, cur, 1'b0);
        cur = nxt(cur);
      end else begin
        step(1'b0, $urandom_range(0, 255), 1'b0);
      end
    end
    check("gapped_lock", int'(locked_a), 1);

    // Single corruption while locked.
    bad(1);
    check("single_cnt",    int'(cnt_a),    1);
    check("single_locked", int'(locked_a), 1);
    good(6);

    // Three bad then one good keeps lock; four bad in a row drops it.
    bad(3);
    good(1);
    check("three_bad_locked", int'(locked_a), 1);
    check("three_bad_cnt",    int'(cnt_a),    4);
    bad(LOSS_CNT);
    check("loss_state", int'(state_a), 0);
    check("loss_cnt",   int'(cnt_a),   8);
    check("sat_cnt",    int'(cnt_s),   3);

    // Mismatch in VERIFY reseeds without counting.
    good(1);
    step(1'b1, cur ^ 8'h02, 1'b0);
    cur = nxt(cur ^ 8'h02);
    check("verify_reseed", int'(state_a), 1);
    check("verify_nocnt",  int'(cnt_a),   8);
    good(LOCK_CNT);
    check("relock", int'(locked_a), 1);

    // Clear coinciding with a mismatch.
    step(1'b1, cur ^ 8'h01, 1'b1);
    cur = nxt(cur);
    check("clear_err", int'(err_a), 1);
    check("clear_cnt", int'(cnt_a), 0);
    good(3);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic v;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 9) < 8);
      if (r < 85)      d = cur;
      else if (r < 93) d = cur ^ (8'h01 << $urandom_range(0, 7));
      else if (r < 97) d = 8'h00;
      else             d = 8'($urandom_range(0, 255));
      step(v, d, ($urandom_range(0, 49) == 0));
      if (v) cur = nxt(cur);
      if ($urandom_range(0, 199) == 0) cur = 8'($urandom_range(1, 255));
      if (k == 1500) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
